// File: rtl/kplic_claim_seq_pkg.sv
// ----------------------------------------------------------------------------
// kplic_claim_seq_pkg : shared widths, register offset and FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package kplic_claim_seq_pkg;

  localparam int unsigned C_INT_WIDTH  = 5;
  localparam int unsigned C_DATA_WIDTH = 32;
  localparam logic [11:0] C_CLAIM_ADDR = 12'h204;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE        = 3'd0;
  localparam logic [STATE_W-1:0] S_CLAIM_RD    = 3'd1;
  localparam logic [STATE_W-1:0] S_CLAIM_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] S_DELIVER     = 3'd3;
  localparam logic [STATE_W-1:0] S_SERVICE     = 3'd4;
  localparam logic [STATE_W-1:0] S_COMPLETE_WR = 3'd5;
  localparam logic [STATE_W-1:0] S_HOLD        = 3'd6;

  typedef struct packed {
    logic        valid;
    logic        wr1_rd0;
    logic [11:0] addr;
  } regbus_req_t;

  function automatic logic state_is_busy(input logic [STATE_W-1:0] st);
    return st != S_IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kplic_claim_seq_if.sv
// ----------------------------------------------------------------------------
// kplic_claim_seq_if : software bus, register bus and core ID handshake
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface kplic_claim_seq_if
  import kplic_claim_seq_pkg::*;
#(
  parameter int INT_WIDTH  = C_INT_WIDTH,
  parameter int DATA_WIDTH = C_DATA_WIDTH
);

  logic                  sw_valid;
  logic [11:0]           sw_addr;
  logic                  sw_wr1_rd0;
  logic [DATA_WIDTH-1:0] sw_wdata;
  logic [DATA_WIDTH-1:0] sw_rdata;

  logic                  reg_valid;
  logic [11:0]           reg_addr;
  logic                  reg_wr1_rd0;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;

  logic                  irq_id_valid;
  logic [INT_WIDTH-1:0]  irq_id;
  logic                  irq_id_ready;
  logic                  irq_done;

  modport slave (
    input  sw_valid, sw_addr, sw_wr1_rd0, sw_wdata,
    output sw_rdata,
    output reg_valid, reg_addr, reg_wr1_rd0, reg_wdata,
    input  reg_rdata,
    output irq_id_valid, irq_id,
    input  irq_id_ready, irq_done
  );

  modport master (
    output sw_valid, sw_addr, sw_wr1_rd0, sw_wdata,
    input  sw_rdata,
    input  reg_valid, reg_addr, reg_wr1_rd0, reg_wdata,
    output reg_rdata,
    input  irq_id_valid, irq_id,
    output irq_id_ready, irq_done
  );

endinterface

`default_nettype wire

// File: rtl/kplic_seq_timer.sv
// ----------------------------------------------------------------------------
// kplic_seq_timer : loadable down-counter with expiry flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module kplic_seq_timer #(
  parameter int WIDTH = 11
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_expired
);

  logic [WIDTH-1:0] r_count;

  // Saturates at zero so expiry stays asserted until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/kplic_claim_seq.sv
// ----------------------------------------------------------------------------
// kplic_claim_seq : auto claim/complete sequencer with software-priority bus mux
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module kplic_claim_seq
  import kplic_claim_seq_pkg::*;
#(
  parameter int          INT_WIDTH  = C_INT_WIDTH,
  parameter int          DATA_WIDTH = C_DATA_WIDTH,
  parameter logic [11:0] CLAIM_ADDR = C_CLAIM_ADDR,
  parameter int          TIMEOUT    = 1024,
  parameter int          HOLDOFF    = 2
) (
  input  wire logic         kplic_clk,
  input  wire logic         kplic_rst,
  input  wire logic         seq_en,
  input  wire logic         kplic_int,
  kplic_claim_seq_if.slave  bus,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] C_TMO_LOAD  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLDOFF - 1);

  logic [STATE_W-1:0]    r_state;
  logic [STATE_W-1:0]    w_state_nxt;
  logic [INT_WIDTH-1:0]  r_id;

  logic                  w_tmr_load;
  logic [CNT_W-1:0]      w_tmr_val;
  logic                  w_tmr_dec;
  logic                  w_tmr_expired;

  regbus_req_t           w_seq_req;
  logic [DATA_WIDTH-1:0] w_seq_wdata;
  logic                  w_seq_issue;

  // Sequencer's own bus request; it only reaches the bus when software is idle.
  always_comb begin
    w_seq_req   = '0;
    w_seq_wdata = '0;
    if ((r_state == S_CLAIM_RD) && seq_en) begin
      w_seq_req.valid   = 1'b1;
      w_seq_req.wr1_rd0 = 1'b0;
      w_seq_req.addr    = CLAIM_ADDR;
    end else if (r_state == S_COMPLETE_WR) begin
      w_seq_req.valid   = 1'b1;
      w_seq_req.wr1_rd0 = 1'b1;
      w_seq_req.addr    = CLAIM_ADDR;
      w_seq_wdata[INT_WIDTH-1:0] = r_id;
    end
  end

  assign w_seq_issue = w_seq_req.valid && !bus.sw_valid;

  always_comb begin
    if (bus.sw_valid) begin
      bus.reg_valid   = 1'b1;
      bus.reg_addr    = bus.sw_addr;
      bus.reg_wr1_rd0 = bus.sw_wr1_rd0;
      bus.reg_wdata   = bus.sw_wdata;
    end else begin
      bus.reg_valid   = w_seq_req.valid;
      bus.reg_addr    = w_seq_req.addr;
      bus.reg_wr1_rd0 = w_seq_req.wr1_rd0;
      bus.reg_wdata   = w_seq_wdata;
    end
  end

  assign bus.sw_rdata = bus.reg_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = C_TMO_LOAD;
    case (r_state)
      S_IDLE: begin
        if (seq_en && kplic_int) w_state_nxt = S_CLAIM_RD;
      end
      S_CLAIM_RD: begin
        if (!seq_en)          w_state_nxt = S_IDLE;
        else if (w_seq_issue) w_state_nxt = S_CLAIM_WAIT;
      end
      S_CLAIM_WAIT: begin
        if (bus.reg_rdata[INT_WIDTH-1:0] == '0) begin
          w_state_nxt = S_HOLD;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_HOLD_LOAD;
        end else begin
          w_state_nxt = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (bus.irq_id_ready) begin
          w_state_nxt = S_SERVICE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_TMO_LOAD;
        end
      end
      S_SERVICE: begin
        if (bus.irq_done || w_tmr_expired) w_state_nxt = S_COMPLETE_WR;
      end
      S_COMPLETE_WR: begin
        if (w_seq_issue) begin
          w_state_nxt = S_HOLD;
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (w_tmr_expired) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_tmr_dec = (r_state == S_SERVICE) || (r_state == S_HOLD);

  kplic_seq_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (kplic_clk),
    .rst        (kplic_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_expired  (w_tmr_expired)
  );

  always_ff @(posedge kplic_clk or posedge kplic_rst) begin
    if (kplic_rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLAIM_WAIT) r_id <= bus.reg_rdata[INT_WIDTH-1:0];
    end
  end

  assign bus.irq_id_valid = (r_state == S_DELIVER);
  assign bus.irq_id       = r_id;
  assign busy             = state_is_busy(r_state);
  // Fires in the expiry cycle itself so a coincident irq_done can suppress it.
  assign timeout_err      = (r_state == S_SERVICE) && w_tmr_expired && !bus.irq_done;

endmodule

`default_nettype wire

// File: tb/tb_kplic_claim_seq.sv
// ----------------------------------------------------------------------------
// tb_kplic_claim_seq : directed and randomized checks of the claim sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_kplic_claim_seq;
  import kplic_claim_seq_pkg::*;

  localparam int          IW  = 5;
  localparam int          DW  = 32;
  localparam int          TMO = 8;
  localparam int          HO  = 2;
  localparam logic [11:0] CA  = 12'h204;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic seq_en = 1'b0;
  logic kint = 1'b0;
  logic busy;
  logic terr;
  int   checks = 0;
  int   errors = 0;

  kplic_claim_seq_if #(.INT_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  kplic_claim_seq #(
    .INT_WIDTH  (IW),
    .DATA_WIDTH (DW),
    .CLAIM_ADDR (CA),
    .TIMEOUT    (TMO),
    .HOLDOFF    (HO)
  ) dut (
    .kplic_clk   (clk),
    .kplic_rst   (rst),
    .seq_en      (seq_en),
    .kplic_int   (kint),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (terr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    seq_en = 0; kint = 0;
    bus.sw_valid = 0; bus.sw_addr = '0; bus.sw_wr1_rd0 = 0; bus.sw_wdata = '0;
    bus.reg_rdata = '0; bus.irq_id_ready = 0; bus.irq_done = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); #1;
      if (!busy) begin ok = 1; break; end
    end
  endtask

  // Runs IDLE -> claim read -> ID return; returns sampled in the DELIVER cycle.
  task automatic start_claim(input logic [IW-1:0] id);
    tick(); seq_en = 1; kint = 1;
    tick(); kint = 0;
    tick(); bus.reg_rdata = DW'(id);
    tick(); bus.reg_rdata = '0; #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if ({busy, terr, bus.irq_id_valid, bus.irq_id} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b terr=%b v=%b id=%0d want all 0", busy, terr, bus.irq_id_valid, bus.irq_id);
    end
    checks++;
    if ({bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata} !== '0) begin
      errors++; $display("FAIL reset_bus: got v=%b wr=%b a=%h d=%h want all 0", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata);
    end
    #2 rst = 0;
  endtask

  task automatic test_basic_claim();
    bit ok;
    tick(); seq_en = 1; kint = 1; #1;
    checks++;
    if ({busy, bus.reg_valid} !== 2'b00) begin
      errors++; $display("FAIL basic_idle: got busy=%b reg_valid=%b want 0 0", busy, bus.reg_valid);
    end
    tick(); kint = 0; #1;
    checks++;
    if ({bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr} !== {1'b1, 1'b0, CA}) begin
      errors++; $display("FAIL basic_claim_rd: got v=%b wr=%b a=%h want 1 0 204", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr);
    end
    tick(); bus.reg_rdata = 32'd5; #1;
    checks++;
    if (bus.irq_id_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b want 0", bus.irq_id_valid);
    end
    tick(); bus.reg_rdata = '0; #1;
    checks++;
    if ({bus.irq_id_valid, bus.irq_id} !== {1'b1, 5'd5}) begin
      errors++; $display("FAIL basic_deliver: got v=%b id=%0d want 1 5", bus.irq_id_valid, bus.irq_id);
    end
    bus.irq_id_ready = 1;
    tick(); bus.irq_id_ready = 0; #1;
    checks++;
    if (bus.irq_id_valid !== 1'b0) begin
      errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.irq_id_valid);
    end
    bus.irq_done = 1;
    tick(); bus.irq_done = 0; #1;
    checks++;
    if ({bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata} !== {1'b1, 1'b1, CA, 32'h5}) begin
      errors++; $display("FAIL basic_complete_wr: got v=%b wr=%b a=%h d=%h want 1 1 204 00000005", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata);
    end
    for (int k = 1; k <= HO + 1; k++) begin
      tick(); #1;
      checks++;
      if ({busy, bus.reg_valid} !== {(k <= HO), 1'b0}) begin
        errors++; $display("FAIL basic_hold_%0d: got busy=%b reg_valid=%b want %b 0", k, busy, bus.reg_valid, (k <= HO));
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_spurious();
    bit ok;
    tick(); seq_en = 1; kint = 1;
    tick(); kint = 0;
    tick(); bus.reg_rdata = 32'hFFFF_FFE0;
    for (int k = 1; k <= HO + 1; k++) begin
      tick(); bus.reg_rdata = '0; #1;
      checks++;
      if ({bus.irq_id_valid, bus.reg_valid, busy} !== {1'b0, 1'b0, (k <= HO)}) begin
        errors++; $display("FAIL spurious_%0d: got v=%b reg_valid=%b busy=%b want 0 0 %b", k, bus.irq_id_valid, bus.reg_valid, busy, (k <= HO));
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_arbitration();
    logic [IW-1:0] id;
    bit ok;
    id = IW'($urandom_range(1, 31));
    tick(); seq_en = 1; kint = 1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 3; k++) begin
        tick(); kint = 0; bus.irq_done = 0;
        bus.sw_valid = 1; bus.sw_addr = 12'($urandom); bus.sw_wr1_rd0 = 1'($urandom);
        bus.sw_wdata = $urandom; bus.reg_rdata = $urandom; #1;
        checks++;
        if ({bus.reg_valid, bus.reg_addr, bus.reg_wr1_rd0, bus.reg_wdata} !== {1'b1, bus.sw_addr, bus.sw_wr1_rd0, bus.sw_wdata}) begin
          errors++; $display("FAIL arb_mirror_%0d_%0d: got a=%h wr=%b d=%h want a=%h wr=%b d=%h", ph, k, bus.reg_addr, bus.reg_wr1_rd0, bus.reg_wdata, bus.sw_addr, bus.sw_wr1_rd0, bus.sw_wdata);
        end
        checks++;
        if (bus.sw_rdata !== bus.reg_rdata) begin
          errors++; $display("FAIL arb_rdata_%0d_%0d: got %h want %h", ph, k, bus.sw_rdata, bus.reg_rdata);
        end
      end
      tick(); bus.sw_valid = 0; bus.reg_rdata = '0; #1;
      checks++;
      if (ph == 0 && {bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr} !== {1'b1, 1'b0, CA}) begin
        errors++; $display("FAIL arb_claim_rd: got v=%b wr=%b a=%h want 1 0 204", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr);
      end
      if (ph == 1 && {bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata} !== {1'b1, 1'b1, CA, DW'(id)}) begin
        errors++; $display("FAIL arb_complete_wr: got v=%b wr=%b a=%h d=%h want 1 1 204 %h", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata, DW'(id));
      end
      if (ph == 0) begin
        tick(); bus.reg_rdata = DW'(id);
        tick(); bus.reg_rdata = '0; bus.irq_id_ready = 1; #1;
        checks++;
        if ({bus.irq_id_valid, bus.irq_id} !== {1'b1, id}) begin
          errors++; $display("FAIL arb_deliver: got v=%b id=%0d want 1 %0d", bus.irq_id_valid, bus.irq_id, id);
        end
        tick(); bus.irq_id_ready = 0; bus.irq_done = 1;
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL arb_idle: busy still %b want 0", busy); end
  endtask

  task automatic test_timeout();
    logic [IW-1:0] id;
    bit ok;
    id = IW'($urandom_range(1, 31));
    start_claim(id);
    bus.irq_id_ready = 1;
    for (int k = 1; k <= TMO + 1; k++) begin
      tick(); bus.irq_id_ready = 0; #1;
      checks++;
      if (terr !== (k == TMO)) begin
        errors++; $display("FAIL timeout_err_k%0d: got %b want %b", k, terr, (k == TMO));
      end
    end
    checks++;
    if ({bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata} !== {1'b1, 1'b1, CA, DW'(id)}) begin
      errors++; $display("FAIL timeout_wr: got v=%b wr=%b a=%h d=%h want 1 1 204 %h", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata, DW'(id));
    end
    wait_idle(ok);
  endtask

  task automatic test_seq_drop();
    logic [IW-1:0] id;
    bit ok;
    id = IW'($urandom_range(1, 31));
    start_claim(id);
    bus.irq_id_ready = 1;
    tick(); bus.irq_id_ready = 0; seq_en = 0;
    tick();
    tick(); bus.irq_done = 1;
    tick(); bus.irq_done = 0; #1;
    checks++;
    if ({bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata, terr} !== {1'b1, 1'b1, CA, DW'(id), 1'b0}) begin
      errors++; $display("FAIL seqdrop_wr: got v=%b wr=%b a=%h d=%h terr=%b want 1 1 204 %h 0", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata, terr, DW'(id));
    end
    wait_idle(ok);
  endtask

  task automatic test_coincident();
    logic [IW-1:0] id;
    bit ok;
    id = IW'($urandom_range(1, 31));
    start_claim(id);
    bus.irq_id_ready = 1;
    for (int k = 1; k <= TMO; k++) begin
      tick(); bus.irq_id_ready = 0; bus.irq_done = (k == TMO); #1;
      checks++;
      if (terr !== 1'b0) begin errors++; $display("FAIL coincident_terr_k%0d: got %b want 0", k, terr); end
    end
    tick(); bus.irq_done = 0; #1;
    checks++;
    if ({bus.reg_valid, bus.reg_wr1_rd0, bus.reg_wdata, terr} !== {1'b1, 1'b1, DW'(id), 1'b0}) begin
      errors++; $display("FAIL coincident_wr: got v=%b wr=%b d=%h terr=%b want 1 1 %h 0", bus.reg_valid, bus.reg_wr1_rd0, bus.reg_wdata, terr, DW'(id));
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_in_deliver();
    logic [IW-1:0] id;
    bit saw_wr;
    id = IW'($urandom_range(1, 31));
    start_claim(id);
    checks++;
    if (bus.irq_id_valid !== 1'b1) begin errors++; $display("FAIL rstdlv_pre: got v=%b want 1", bus.irq_id_valid); end
    rst = 1; #1;
    checks++;
    if ({busy, terr, bus.irq_id_valid, bus.irq_id, bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata} !== '0) begin
      errors++; $display("FAIL rstdlv_outputs: got busy=%b terr=%b v=%b id=%0d rv=%b a=%h d=%h want all 0", busy, terr, bus.irq_id_valid, bus.irq_id, bus.reg_valid, bus.reg_addr, bus.reg_wdata);
    end
    tick(); tick(); rst = 0; seq_en = 1;
    saw_wr = 0;
    for (int k = 0; k < 12; k++) begin
      tick(); bus.irq_done = (k == 2); #1;
      if (bus.reg_valid || busy) saw_wr = 1;
    end
    bus.irq_done = 0;
    checks++;
    if (saw_wr) begin errors++; $display("FAIL rstdlv_no_write: got bus activity=1 want 0"); end
  endtask

  // Reference timeline: each event is the first software-free cycle at or after
  // the cycle the preceding rule makes it due.
  task automatic test_random_txns();
    logic [IW-1:0] id;
    logic [DW-1:0] zid;
    logic [45:0]   got, exp, msk;
    int  c, rd, hs, wr, fin, rdly, d, due;
    bit  tmo, drop, sw_v, exp_rd, exp_wr, exp_v, exp_te, exp_busy, done_ok, ok;
    for (int t = 0; t < 25; t++) begin
      id   = IW'($urandom_range(0, 31));
      zid  = DW'(id);
      rdly = $urandom_range(0, 3);
      d    = $urandom_range(0, TMO + 3);
      tmo  = (d >= TMO);
      drop = 1'($urandom);
      rd = -1; hs = -1; wr = -1; fin = -1; done_ok = 0;
      for (c = 0; c < 120; c++) begin
        tick();
        sw_v = ($urandom_range(0, 2) == 0);
        bus.sw_valid = sw_v; bus.sw_addr = 12'($urandom);
        bus.sw_wr1_rd0 = 1'($urandom); bus.sw_wdata = $urandom;
        kint   = (rd < 0);
        seq_en = !(drop && hs >= 0);
        bus.reg_rdata    = (rd >= 0 && c == rd + 1) ? zid : DW'($urandom);
        bus.irq_id_ready = (id != 0 && rd >= 0 && c >= rd + 2 + rdly);
        bus.irq_done     = (hs >= 0) ? (!tmo && c == hs + 1 + d) : ($urandom_range(0, 3) == 0);
        #1;
        due      = tmo ? hs + TMO + 1 : hs + 2 + d;
        exp_rd   = (rd < 0 && c >= 1 && !sw_v);
        exp_wr   = (id != 0 && hs >= 0 && wr < 0 && c >= due && !sw_v);
        exp_v    = (id != 0 && rd >= 0 && c >= rd + 2 && hs < 0);
        exp_te   = (tmo && hs >= 0 && c == hs + TMO);
        exp_busy = (c >= 1) && !(fin >= 0 && c >= fin);
        got = {bus.reg_valid, bus.reg_wr1_rd0, bus.reg_addr, bus.reg_wdata};
        if (sw_v)        begin exp = {1'b1, bus.sw_wr1_rd0, bus.sw_addr, bus.sw_wdata}; msk = '1; end
        else if (exp_wr) begin exp = {1'b1, 1'b1, CA, zid};  msk = '1; end
        else if (exp_rd) begin exp = {1'b1, 1'b0, CA, 32'h0}; msk = {14'h3FFF, 32'h0}; end
        else             begin exp = '0; msk = {1'b1, 45'h0}; end
        checks++;
        if ((got & msk) !== (exp & msk)) begin
          errors++; $display("FAIL rnd%0d_bus_c%0d: got %h want %h (mask %h)", t, c, got, exp, msk);
        end
        checks++;
        if (bus.sw_rdata !== bus.reg_rdata) begin
          errors++; $display("FAIL rnd%0d_rdata_c%0d: got %h want %h", t, c, bus.sw_rdata, bus.reg_rdata);
        end
        checks++;
        if (bus.irq_id_valid !== exp_v || (exp_v && bus.irq_id !== id)) begin
          errors++; $display("FAIL rnd%0d_deliver_c%0d: got v=%b id=%0d want v=%b id=%0d", t, c, bus.irq_id_valid, bus.irq_id, exp_v, id);
        end
        checks++;
        if ({terr, busy} !== {exp_te, exp_busy}) begin
          errors++; $display("FAIL rnd%0d_status_c%0d: got terr=%b busy=%b want %b %b", t, c, terr, busy, exp_te, exp_busy);
        end
        if (exp_rd) rd = c;
        if (exp_v && bus.irq_id_ready) hs = c;
        if (exp_wr) begin wr = c; fin = c + HO + 1; end
        if (id == 0 && rd >= 0 && fin < 0) fin = rd + 2 + HO;
        if (fin >= 0 && c >= fin) begin done_ok = 1; break; end
      end
      checks++;
      if (!done_ok) begin errors++; $display("FAIL rnd%0d_stall: txn id=%0d did not complete in 120 cycles", t, id); end
      idle_inputs();
      wait_idle(ok);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_claim();
    test_spurious();
    test_arbitration();
    test_timeout();
    test_seq_drop();
    test_coincident();
    test_reset_in_deliver();
    idle_inputs();
    test_random_txns();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
